// File: rtl/mantissa_multiplier_iter.sv
// Iterative unsigned W x W mantissa multiplier (W = SUB_W*SUB_N) with 1/2/4-lane SIMD modes.
// One B chunk is folded into a 2W-bit accumulator per cycle using a single row of SUB_N sub-multipliers.
module mantissa_multiplier_iter #(
  parameter int SUB_W = 7,
  parameter int SUB_N = 4,
  localparam int W = SUB_W * SUB_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out,
  output logic [1:0]       op_out,
  output logic [1:0]       fsm_state
);

  localparam int CW = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SUB_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [1:0]      op_reg;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;

  logic [2*W-1:0]     step_sum;
  logic [2*SUB_W-1:0] pp;
  logic [SUB_W-1:0]   b_chunk;
  logic               same_lane;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid depend on state only, so out_ready never reaches in_ready combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = acc;
  assign op_out    = op_reg;
  assign fsm_state = state;

  // Partial products outside the current B chunk's lane are dropped, so no carry crosses a lane field.
  always_comb begin
    step_sum  = '0;
    pp        = '0;
    same_lane = 1'b0;
    b_chunk   = b_reg[int'(cnt)*SUB_W +: SUB_W];
    for (int j = 0; j < SUB_N; j++) begin
      case (op_reg)
        2'b01:   same_lane = (j / (SUB_N/2)) == (int'(cnt) / (SUB_N/2));
        2'b10:   same_lane = (j / (SUB_N/4)) == (int'(cnt) / (SUB_N/4));
        default: same_lane = 1'b1;
      endcase
      pp = {{SUB_W{1'b0}}, a_reg[j*SUB_W +: SUB_W]} * {{SUB_W{1'b0}}, b_chunk};
      if (same_lane) begin
        step_sum = step_sum + ({{(2*W-2*SUB_W){1'b0}}, pp} << ((int'(cnt) + j) * SUB_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= op;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc + step_sum;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_multiplier_iter.sv
// Bench for mantissa_multiplier_iter: directed cases, backpressure, async reset, and a random stream
// checked in order against a per-lane product model.
module tb_mantissa_multiplier_iter;

  localparam int W  = 28;
  localparam int HW = W / 2;
  localparam int QW = W / 4;
  localparam int N_RAND = 1000;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [1:0]     op_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic [1:0]     op_out;
  logic [1:0]     fsm_state;

  logic           rand_bp;
  logic           rand_or;
  logic           dir_or;
  logic           sb_on;

  int n_pass;
  int n_tot;
  int n_done;

  logic [2*W+1:0] exp_q[$];

  assign out_ready = rand_bp ? rand_or : dir_or;

  mantissa_multiplier_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .op        (op_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .op_out    (op_out),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    rand_or = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // reference: independent per-lane unsigned products
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] r;
    logic [2*W-1:0] fa, fb;
    logic [W-1:0]   ha, hb;
    logic [HW-1:0]  qa, qb;
    r = '0;
    case (o)
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          ha = {{HW{1'b0}}, a[k*HW +: HW]};
          hb = {{HW{1'b0}}, b[k*HW +: HW]};
          r[k*W +: W] = ha * hb;
        end
      end
      2'b10: begin
        for (int k = 0; k < 4; k++) begin
          qa = {{QW{1'b0}}, a[k*QW +: QW]};
          qb = {{QW{1'b0}}, b[k*QW +: QW]};
          r[k*HW +: HW] = qa * qb;
        end
      end
      default: begin
        fa = {{W{1'b0}}, a};
        fb = {{W{1'b0}}, b};
        r  = fa * fb;
      end
    endcase
    return r;
  endfunction

  // scoreboard compare process
  logic           held;
  logic [2*W-1:0] prev_out;
  logic [1:0]     prev_op;
  always @(negedge clk) begin
    logic [2*W+1:0] e;
    if (sb_on && rst_n) begin
      if (out_valid && held) begin
        chk("out_stable", 64'(out), 64'(prev_out));
        chk("op_out_stable", 64'(op_out), 64'(prev_op));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rand_out", 64'(out), 64'(e[2*W-1:0]));
          chk("rand_op_out", 64'(op_out), 64'(e[2*W+1:2*W]));
          n_done++;
        end
        held = 1'b0;
      end else begin
        held = out_valid;
      end
      prev_out = out;
      prev_op  = op_out;
    end else begin
      held = 1'b0;
    end
  end

  // driver tasks
  task automatic accept(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int budget;
    @(posedge clk);
    #1;
    a_in = a; b_in = b; op_in = o; in_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); op_in = 2'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic directed(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] lit);
    int lat;
    accept(o, a, b);
    wait_valid(lat);
    chk({name, "_latency"}, 64'(lat), 64'(4));
    chk({name, "_out"}, 64'(out), 64'(lit));
    chk({name, "_model"}, 64'(out), 64'(model(o, a, b)));
    chk({name, "_op_out"}, 64'(op_out), 64'(o));
    dir_or = 1'b1;
    @(posedge clk);
    #1;
    dir_or = 1'b0;
    chk({name, "_in_ready_after"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [2*W-1:0] four_lit;
    logic [2*W-1:0] hold_out;
    logic [1:0]     hold_op;
    logic [W-1:0]   na, nb;
    logic [1:0]     no;
    logic [1:0]     idle_code;
    int             lat;
    int             budget;

    n_pass = 0; n_tot = 0; n_done = 0;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
    rand_bp = 1'b0; dir_or = 1'b0; sb_on = 1'b0;
    four_lit = {4{14'h3F01}};

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_op_out", 64'(op_out), 64'(0));
    idle_code = fsm_state;
    @(negedge clk);
    rst_n = 1'b1;

    // pin the model to hand-computed values
    chk("model_full", 64'(model(2'b00, 28'hFFFFFFF, 28'hFFFFFFF)), 64'(56'hFFFFFFE0000001));
    chk("model_two", 64'(model(2'b01, {14'd3, 14'd100}, {14'd5, 14'd7})), 64'(56'h000000F00002BC));
    chk("model_four", 64'(model(2'b10, {4{7'h7F}}, {4{7'h7F}})), 64'(four_lit));
    chk("model_op11", 64'(model(2'b11, 28'd2, 28'd3)), 64'(6));
    chk("model_zero", 64'(model(2'b00, 28'd0, 28'h1234567)), 64'(0));

    directed("full_ones", 2'b00, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001);
    directed("full_zero", 2'b00, 28'd0, 28'h1234567, 56'd0);
    directed("two_lane", 2'b01, {14'd3, 14'd100}, {14'd5, 14'd7}, 56'h000000F00002BC);
    directed("four_lane", 2'b10, {4{7'h7F}}, {4{7'h7F}}, four_lit);
    directed("op11", 2'b11, 28'd2, 28'd3, 56'd6);
    directed("two_lane_max", 2'b01, 28'hFFFFFFF, 28'hFFFFFFF, {2{28'hFFF8001}});

    // backpressure
    accept(2'b01, 28'h0ABCDEF, 28'h1357924);
    wait_valid(lat);
    hold_out = out;
    hold_op  = op_out;
    chk("bp_out", 64'(out), 64'(model(2'b01, 28'h0ABCDEF, 28'h1357924)));
    na = 28'h89ABCDE; nb = 28'h7654321; no = 2'b10;
    a_in = na; b_in = nb; op_in = no; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_out", 64'(out), 64'(hold_out));
      chk("bp_hold_op", 64'(op_out), 64'(hold_op));
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    end
    dir_or = 1'b1;
    @(posedge clk);
    #1;
    dir_or = 1'b0;
    chk("bp_in_ready_high", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    chk("bp_accepted", 64'(in_ready), 64'(0));
    wait_valid(lat);
    chk("bp_new_latency", 64'(lat), 64'(4));
    chk("bp_new_out", 64'(out), 64'(model(no, na, nb)));
    chk("bp_new_op", 64'(op_out), 64'(no));
    dir_or = 1'b1;
    @(posedge clk);
    #1;
    dir_or = 1'b0;

    // async reset in the middle of CALC
    accept(2'b00, 28'hFFFFFFF, 28'h0F0F0F0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'(0));
    chk("rstmid_in_ready", 64'(in_ready), 64'(1));
    chk("rstmid_out", 64'(out), 64'(0));
    chk("rstmid_state", 64'(fsm_state), 64'(idle_code));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_no_resume", 64'(out_valid), 64'(0));
    directed("after_reset", 2'b00, 28'd5, 28'd7, 56'd35);

    // random back-to-back stream
    sb_on = 1'b1;
    rand_bp = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = '1;
      if ($urandom_range(0, 15) == 0) ra = '0;
      exp_q.push_back({ro, model(ro, ra, rb)});
      accept(ro, ra, rb);
    end
    budget = 0;
    while (n_done < N_RAND && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    chk("rand_count", 64'(n_done), 64'(N_RAND));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));
    sb_on = 1'b0;
    rand_bp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mantissa_multiplier_iter.md
# mantissa_multiplier_iter

Parametrised, iterative successor to the combinational 28×28 mantissa multiplier in the posit FMA datapath. It computes an unsigned W×W product, or 2 or 4 independent SIMD lane products, using one row of SUB_N sub-multipliers. Each cycle it folds one B chunk into a 2W-bit accumulator. Operands and results move over valid/ready handshakes, so the block can sit between the decode and the accumulate/normalise stages of the FMAU.

## Interface

**Parameters**
- `SUB_W`, default 7: width of one sub-multiplier operand.
- `SUB_N`, default 4: number of chunks per operand. Must be a multiple of 4. W = SUB_W*SUB_N (28 by default).

**Ports**
- `clk` input, 1 bit: the only clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operand set is valid.
- `in_ready` output, 1 bit: block can accept operands.
- `A` input, W bits: multiplicand.
- `B` input, W bits: multiplier.
- `op` input, 2 bits: mode select.
  - 00: one W×W product.
  - 01: two (W/2)×(W/2) lanes.
  - 10: four (W/4)×(W/4) lanes.
  - 11: treated as 00.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts result.
- `out` output, 2W bits: product(s).
- `op_out` output, 2 bits: `op` of the returned result.

## Operation

**Lane layout**
- L = lanes (1, 2 or 4), LW = W/L, Lc = SUB_N/L chunks per lane.
- Lane k uses operands `A[k*LW +: LW]` and `B[k*LW +: LW]`.
- Lane k's result goes to `out[2*k*LW +: 2*LW]`.

**States**
- IDLE: `in_ready`=1.
  - On `in_valid`&&`in_ready`, register A, B and op, clear acc and cnt, and go to CALC.
- CALC: one step per cycle, for cnt = 0..SUB_N-1.
  - Bi = B chunk cnt.
  - pp(j) = A chunk j × Bi, unsigned, 2*SUB_W bits, for j = 0..SUB_N-1.
  - pp(j) is gated to zero unless j/Lc == cnt/Lc (same lane).
  - acc += Σ pp(j) << ((cnt+j)*SUB_W).
  - When cnt == SUB_N-1, go to DONE.
- DONE: `out_valid`=1, `out`=acc, `op_out`=registered op.
  - On `out_ready`, go to IDLE.

**Arithmetic**
- acc is 2W bits wide.
- Gating keeps each lane's partial products inside that lane's field, so no carry ever crosses a lane boundary.
- The result is exact, with no truncation.

**Boundary conditions**
- `in_valid` outside IDLE is ignored, because `in_ready`=0. The upstream block must hold its data.
- In DONE with `out_ready`=0, `out` and `op_out` stay stable indefinitely.
- A, B and op are captured at acceptance. Input changes after that have no effect.
- `op` is sampled only at acceptance, so mode switches between transactions need no idle cycles.
- Zero operands take the full latency. There is no early exit.
- `rst_n` low at any time aborts the operation, asynchronously:
  - state goes to IDLE, acc=0, cnt=0, `out_valid`=0;
  - the operation does not resume after reset is released.

## Timing

**Reset values**
- `in_ready`=1, `out_valid`=0, `out`=0, `op_out`=0.

**Latency**
- Operands are accepted at edge E.
- CALC steps occur at edges E+1 .. E+SUB_N.
- `out_valid` is high after edge E+SUB_N, i.e. 4 cycles by default.

**Throughput**
- With `out_ready` tied high, one result every SUB_N+2 cycles:
  - 1 cycle in IDLE,
  - SUB_N cycles in CALC,
  - 1 cycle in DONE.

**Handshake timing**
- `in_ready` and `out_valid` are pure functions of state. There is no combinational path from `out_ready` to `in_ready`.
- The `out` register updates only on CALC edges. It is constant while `out_valid`=1.

## Test plan

- **Full-width multiply:** op=00, A=B=28'hFFFFFFF → `out`=56'hFFFFFFE0000001 with `out_valid` after 4 cycles. Also A=0, B=28'h1234567 → `out`=0.
- **Two lanes:** op=01, A={14'd3,14'd100}, B={14'd5,14'd7} → `out`=56'h000000F00002BC. Check that no bits leak across lanes.
- **Four lanes:** op=10, A=B={4{7'h7F}} → `out`={4{14'h3F01}}. Also op=11 with A=2, B=3 → `out`=6 (full mode).
- **Backpressure:**
  - hold `out_ready`=0 for 10 cycles;
  - `out` and `op_out` stay stable;
  - `in_ready` stays 0 while `in_valid`=1 with new data;
  - raise `out_ready` → one cycle later `in_ready`=1 and the new operands are accepted.
- **Reset mid-CALC:**
  - assert `rst_n`=0 between clock edges at cnt=2;
  - `out_valid` stays 0 and `in_ready`=1 immediately, before the next edge;
  - after release, a new op=00 transaction with 5×7 returns 35.
- **Back-to-back random stream:** 1000 transactions with random op, A and B, and random `in_valid`/`out_ready` gaps. Each result is compared in order against a reference model of the per-lane products, and `op_out` must match.
